// File: rtl/wfg_subcore_sequencer.sv
`default_nettype none
// ============================================================================
// Module : wfg_subcore_sequencer
// Brief  : Subcycle/sync pulse time base for the WFG subcore, with per-period
//          shadowed configuration and graceful (drain-to-boundary) disable.
// Rev    : 1.0  initial release
// ============================================================================

module wfg_subcore_sequencer #(
  parameter int SUBW  = 16,
  parameter int SYNCW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ctrl_en_q_i,
  input  logic [SUBW-1:0]  cfg_subcycle_q_i,
  input  logic [SYNCW-1:0] cfg_sync_q_i,
  output logic             subcycle_pls_o,
  output logic             sync_pls_o,
  output logic [SYNCW-1:0] subcycle_cnt_o,
  output logic             active_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [SUBW-1:0]  clk_cnt_q, clk_cnt_d;
  logic [SYNCW-1:0] sub_cnt_q, sub_cnt_d;
  logic [SUBW-1:0]  sub_sh_q, sub_sh_d;
  logic [SYNCW-1:0] sync_sh_q, sync_sh_d;
  logic             sub_pls_q, sub_pls_d;
  logic             sync_pls_q, sync_pls_d;
  logic             active_q, active_d;

  logic             sub_evt;
  logic             sync_bnd;

  assign sub_evt  = (clk_cnt_q == '0);
  assign sync_bnd = sub_evt && (sub_cnt_q == sync_sh_q);

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    sub_cnt_d  = sub_cnt_q;
    sub_sh_d   = sub_sh_q;
    sync_sh_d  = sync_sh_q;
    sub_pls_d  = 1'b0;
    sync_pls_d = 1'b0;
    active_d   = active_q;

    case (state_q)
      ST_IDLE: begin
        if (ctrl_en_q_i) begin
          state_d   = ST_RUN;
          clk_cnt_d = cfg_subcycle_q_i;
          sub_cnt_d = '0;
          sub_sh_d  = cfg_subcycle_q_i;
          sync_sh_d = cfg_sync_q_i;
          active_d  = 1'b1;
        end
      end

      ST_RUN, ST_DRAIN: begin
        if (sub_evt) begin
          sub_pls_d = 1'b1;
          clk_cnt_d = sub_sh_q;
          if (sync_bnd) begin
            // Config is only sampled here, so a period never sees a torn setting.
            sync_pls_d = 1'b1;
            sub_cnt_d  = '0;
            sub_sh_d   = cfg_subcycle_q_i;
            sync_sh_d  = cfg_sync_q_i;
            clk_cnt_d  = cfg_subcycle_q_i;
            if (!ctrl_en_q_i) begin
              state_d   = ST_IDLE;
              clk_cnt_d = '0;
              active_d  = 1'b0;
            end
          end else begin
            sub_cnt_d = sub_cnt_q + SYNCW'(1);
          end
        end else begin
          clk_cnt_d = clk_cnt_q - SUBW'(1);
        end

        if (!sync_bnd) begin
          state_d = ctrl_en_q_i ? ST_RUN : ST_DRAIN;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        clk_cnt_d = '0;
        sub_cnt_d = '0;
        active_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      clk_cnt_q  <= '0;
      sub_cnt_q  <= '0;
      sub_sh_q   <= '0;
      sync_sh_q  <= '0;
      sub_pls_q  <= 1'b0;
      sync_pls_q <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      sub_cnt_q  <= sub_cnt_d;
      sub_sh_q   <= sub_sh_d;
      sync_sh_q  <= sync_sh_d;
      sub_pls_q  <= sub_pls_d;
      sync_pls_q <= sync_pls_d;
      active_q   <= active_d;
    end
  end

  assign subcycle_pls_o = sub_pls_q;
  assign sync_pls_o     = sync_pls_q;
  assign subcycle_cnt_o = sub_cnt_q;
  assign active_o       = active_q;

endmodule

`default_nettype wire

// File: tb/tb_wfg_subcore_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_wfg_subcore_sequencer
// Brief  : Directed bench for wfg_subcore_sequencer with a period-level model.
// Rev    : 1.0  initial release
// ============================================================================

module tb_wfg_subcore_sequencer;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [15:0] cfg_sub;
  logic [7:0]  cfg_sync;
  logic       subcycle_pls;
  logic       sync_pls;
  logic [7:0] subcycle_cnt;
  logic       active;

  wfg_subcore_sequencer #(.SUBW(16), .SYNCW(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ctrl_en_q_i      (en),
    .cfg_subcycle_q_i (cfg_sub),
    .cfg_sync_q_i     (cfg_sync),
    .subcycle_pls_o   (subcycle_pls),
    .sync_pls_o       (sync_pls),
    .subcycle_cnt_o   (subcycle_cnt),
    .active_o         (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model: a subcycle lasts len clocks, a sync period slen subcycles; elapsed time
  // counts up from the enable edge and lengths are re-read at each period end.
  int m_on, m_el, m_idx, m_len, m_slen, m_pls, m_sync;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_on <= 0; m_el <= 0; m_idx <= 0; m_len <= 0; m_slen <= 0;
      m_pls <= 0; m_sync <= 0;
    end else begin
      m_pls  <= 0;
      m_sync <= 0;
      if (m_on == 0) begin
        if (en) begin
          m_on   <= 1;
          m_el   <= 0;
          m_idx  <= 0;
          m_len  <= int'(cfg_sub) + 1;
          m_slen <= int'(cfg_sync) + 1;
        end
      end else if (m_el + 1 == m_len) begin
        m_pls <= 1;
        m_el  <= 0;
        if (m_idx + 1 == m_slen) begin
          m_sync <= 1;
          m_idx  <= 0;
          m_len  <= int'(cfg_sub) + 1;
          m_slen <= int'(cfg_sync) + 1;
          if (!en) m_on <= 0;
        end else begin
          m_idx <= m_idx + 1;
        end
      end else begin
        m_el <= m_el + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_subcycle_pls", int'(subcycle_pls), m_pls);
    chk("cmp_sync_pls", int'(sync_pls), m_sync);
    chk("cmp_subcycle_cnt", int'(subcycle_cnt), m_idx);
    chk("cmp_active", int'(active), m_on);
  end

  // Pulse monitor: cycle stamps of subcycle pulses and a running sync count.
  int cyc = 0;
  int sync_tot = 0;
  int pq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (subcycle_pls) pq.push_back(cyc);
    if (sync_pls) sync_tot <= sync_tot + 1;
  end

  function automatic int pqget(input int i);
    if (i >= 0 && i < pq.size()) return pq[i];
    return -1000;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk_gaps(input string name, input int first, input int n, input int gap);
    for (int i = 0; i < n; i++)
      chk(name, pqget(first + i) - pqget(first + i - 1), gap);
  endtask

  int e, m0, m1, s0;
  int exp_gap[6] = '{4, 4, 4, 8, 8, 8};

  initial begin
    rst_n = 1'b0; en = 1'b0; cfg_sub = 16'd3; cfg_sync = 8'd2;
    step(2);
    chk("reset_active", int'(active), 0);
    chk("reset_pls", int'(subcycle_pls), 0);
    rst_n = 1'b1;
    step(2);

    // Basic run: sub=3, sync=2
    e = cyc; m0 = pq.size(); s0 = sync_tot; en = 1'b1;
    step(25);
    chk("s1_first_delay", pqget(m0) - (e + 1), 4);
    chk("s1_sub_count", pq.size() - m0, 6);
    chk("s1_sync_count", sync_tot - s0, 2);
    chk_gaps("s1_gap", m0 + 1, 5, 4);

    // Mid-period config write takes effect only after the next sync boundary
    cfg_sub = 16'd7; m0 = pq.size(); s0 = sync_tot;
    step(40);
    chk("s3_sub_count", pq.size() - m0, 6);
    chk("s3_sync_count", sync_tot - s0, 2);
    for (int i = 0; i < 6; i++)
      chk("s3_gap", pqget(m0 + i) - pqget(m0 + i - 1), exp_gap[i]);

    en = 1'b0; cfg_sub = 16'd3;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);

    // Graceful disable after the first pulse of a period
    e = cyc; en = 1'b1;
    step(5);
    en = 1'b0; m1 = pq.size(); s0 = sync_tot;
    step(20);
    chk("s4_drain_subs", pq.size() - m1, 2);
    chk("s4_drain_syncs", sync_tot - s0, 1);
    chk("s4_last_pulse", pqget(pq.size() - 1) - e, 13);
    chk("s4_inactive", int'(active), 0);

    // Drop and re-raise enable before the boundary: identical train
    e = cyc; m0 = pq.size(); s0 = sync_tot; en = 1'b1;
    step(6);
    en = 1'b0;
    step(4);
    en = 1'b1;
    step(15);
    chk("s5_first_delay", pqget(m0) - (e + 1), 4);
    chk("s5_sub_count", pq.size() - m0, 6);
    chk("s5_sync_count", sync_tot - s0, 2);
    chk_gaps("s5_gap", m0 + 1, 5, 4);
    en = 1'b0;
    step(30);
    chk("s5_inactive", int'(active), 0);

    // Continuous pulses: sub=0, sync=0
    cfg_sub = 16'd0; cfg_sync = 8'd0;
    m0 = pq.size(); s0 = sync_tot; en = 1'b1;
    step(10);
    chk("s2_sub_count", pq.size() - m0, 9);
    chk("s2_sync_count", sync_tot - s0, 9);
    chk("s2_cnt_zero", int'(subcycle_cnt), 0);
    en = 1'b0;
    step(3);
    chk("s2_inactive", int'(active), 0);

    // Asynchronous reset in the middle of a subcycle
    cfg_sub = 16'd3; cfg_sync = 8'd2; en = 1'b1;
    step(6);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_active", int'(active), 0);
    chk("s6_rst_cnt", int'(subcycle_cnt), 0);
    chk("s6_rst_pls", int'(subcycle_pls), 0);
    chk("s6_rst_sync", int'(sync_pls), 0);
    step(2);
    e = cyc; m0 = pq.size(); rst_n = 1'b1;
    step(10);
    chk("s6_first_delay", pqget(m0) - (e + 1), 4);
    en = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
